// File: rtl/id_issue_if.sv
// ----------------------------------------------------------------------------
// id_issue_if
//   Instruction handshake between the fetch (IF) stage and the decode/issue
//   stage.
//
//   Signals
//     inst_i        32  instruction word offered by IF
//     inst_valid_i   1  inst_i is valid this cycle
//     inst_ready_o   1  decode consumes inst_i this cycle when valid & ready
//     flush_i        1  drop whatever instruction is currently offered
//
//   Modports
//     master : fetch side (drives the instruction, observes ready)
//     slave  : decode/issue side (observes the instruction, drives ready)
// ----------------------------------------------------------------------------
interface id_issue_if;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        flush_i;

  modport master (
    output inst_i,
    output inst_valid_i,
    output flush_i,
    input  inst_ready_o
  );

  modport slave (
    input  inst_i,
    input  inst_valid_i,
    input  flush_i,
    output inst_ready_o
  );
endinterface : id_issue_if

// File: rtl/id_issue.sv
// ----------------------------------------------------------------------------
// id_issue
//   RV32 decode-and-issue stage feeding the ID/EX pipeline buffer. Decodes the
//   AND/OR/ADD/SUB/MUL/ADDI subset, reads the register file and holds back
//   issue while a source register still has a write in flight. All ID/EX
//   outputs are registered; a cycle with nothing to issue is a bubble.
//
//   Parameters
//     SB_DEPTH  in-flight stages tracked by the scoreboard (EX, MEM, WB)
//     CNT_W     width of the saturating stall counter
//
//   Ports
//     clk_i, rst_i        clock (rising edge), async active-low reset
//     if_bus              instruction handshake from IF (slave side)
//     rf_rs1/2_addr_o     register-file read addresses, combinational
//     rf_rs1/2_data_i     register-file read data, combinational
//     rs1/rs2_data_o      registered operand data to ID/EX
//     imm_o               registered sign-extended immediate (ADDI only)
//     rs1_o/rs2_o/rsd_o   registered register indices to ID/EX
//     Op_o                registered ALU op code
//     valid_o             1 = issued instruction, 0 = bubble
//     illegal_o           one-cycle pulse after accepting an unsupported word
//     stall_cnt_o         saturating count of stall cycles
// ----------------------------------------------------------------------------
module id_issue #(
  parameter int SB_DEPTH = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,

  id_issue_if.slave        if_bus,

  output logic [4:0]       rf_rs1_addr_o,
  output logic [4:0]       rf_rs2_addr_o,
  input  logic [31:0]      rf_rs1_data_i,
  input  logic [31:0]      rf_rs2_data_i,

  output logic [31:0]      rs1_data_o,
  output logic [31:0]      rs2_data_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rsd_o,
  output logic [2:0]       Op_o,
  output logic             valid_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // --------------------------------------------------------------------------
  // Types
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_ADDI = 3'b101
  } op_e;

  // One in-flight writer: destination register plus whether it really writes.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = if_bus.inst_i[6:0];
  assign rd     = if_bus.inst_i[11:7];
  assign funct3 = if_bus.inst_i[14:12];
  assign rs1    = if_bus.inst_i[19:15];
  assign rs2    = if_bus.inst_i[24:20];
  assign funct7 = if_bus.inst_i[31:25];

  // Register-file addresses are presented straight from the raw fields so the
  // read data is ready in the same cycle; whether rs2 matters is decided later.
  assign rf_rs1_addr_o = rs1;
  assign rf_rs2_addr_o = rs2;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic        dec_legal;
  op_e         dec_op;
  logic        dec_use_rs2;
  logic [31:0] dec_imm;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned (no latch).
    dec_legal   = 1'b0;
    dec_op      = OP_AND;
    dec_use_rs2 = 1'b0;
    dec_imm     = '0;

    case (opcode)
      OPC_REG: begin
        dec_use_rs2 = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_op = OP_AND; end
          {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_SUB; end
          {7'b0000001, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_MUL; end
          default: ;
        endcase
      end
      OPC_IMM: begin
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_ADDI;
          dec_imm   = {{20{if_bus.inst_i[31]}}, if_bus.inst_i[31:20]};
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Scoreboard and hazard detection
  // --------------------------------------------------------------------------
  sb_entry_t [SB_DEPTH-1:0] sb_q;
  logic                     hazard;

  // x0 is hard-wired zero, so reading it can never conflict with a writer.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].valid) begin
        if ((rs1 != 5'd0) && (sb_q[i].rd == rs1)) begin
          hazard = 1'b1;
        end
        if (dec_use_rs2 && (rs2 != 5'd0) && (sb_q[i].rd == rs2)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic stall;
  logic issue;
  logic accept_illegal;

  // Flush wins over everything: the offered word is consumed and dropped.
  // Illegal words are never stalled, they are simply swallowed.
  assign stall          = if_bus.inst_valid_i & dec_legal & hazard & ~if_bus.flush_i;
  assign issue          = if_bus.inst_valid_i & dec_legal & ~hazard & ~if_bus.flush_i;
  assign accept_illegal = if_bus.inst_valid_i & ~dec_legal & ~if_bus.flush_i;

  assign if_bus.inst_ready_o = ~stall;

  // --------------------------------------------------------------------------
  // Scoreboard shift register
  // --------------------------------------------------------------------------
  // Entry 0 is written on every edge, so bubbles push an empty slot in and the
  // oldest writer ages out after exactly SB_DEPTH cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: the scoreboard is a tiny register array, not a RAM; it must be
    // reset because stale valid bits would cause phantom stalls after reset.
    if (!rst_i) begin
      sb_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // shifts from the pre-edge value regardless of statement order.
      sb_q[0].valid <= issue & (rd != 5'd0);
      sb_q[0].rd    <= issue ? rd : 5'd0;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o    <= 1'b0;
      Op_o       <= 3'b000;
      rsd_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end else if (issue) begin
      valid_o    <= 1'b1;
      Op_o       <= dec_op;
      rsd_o      <= rd;
      rs1_o      <= rs1;
      rs1_data_o <= rf_rs1_data_i;
      // ADDI's rs2 field holds immediate bits; present it as unused.
      rs2_o      <= dec_use_rs2 ? rs2 : 5'd0;
      rs2_data_o <= dec_use_rs2 ? rf_rs2_data_i : 32'd0;
      imm_o      <= dec_imm;
    end else begin
      valid_o    <= 1'b0;
      Op_o       <= 3'b000;
      rsd_o      <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Illegal pulse and stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_o   <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      illegal_o <= accept_illegal;
      if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule : id_issue
